geofence_param: RTL and testbench

//  Parametrised point-in-convex-polygon engine, the next-generation geofence core.

---
 rtl/geofence_param.sv | 156 +++++++++++++++
 tb/tb_geofence_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/geofence_param.sv
// Point-in-convex-polygon engine: loads P and NV fence vertices, angle-sorts the
// vertices about v[0], then walks the edges and reports inside/outside and on-edge.
//
// state | meaning
// LOAD  | capture P then v[0..NV-1]; in_valid=0 cycles are gaps
// SORT  | bubble sort v[1..NV-1] about pivot v[0], one compare per cycle
// JUDGE | test P against edge k, stop early on a negative cross product
// OUT   | one-cycle valid pulse, then back to LOAD
module geofence_param #(
  parameter int W         = 10,
  parameter int NV        = 6,
  parameter int INCL_EDGE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic         busy,
  output logic         valid,
  output logic         is_inside,
  output logic         on_edge
);
  localparam int AW = $clog2(NV);

  typedef enum logic [1:0] {LOAD, SORT, JUDGE, OUT} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   r_lim;
  logic            r_have_p;
  logic            r_flag;
  logic [W-1:0]    r_px, r_py;
  logic [W-1:0]    r_vx [NV];
  logic [W-1:0]    r_vy [NV];

  logic [AW-1:0]       w_ia, w_ib;
  logic [W-1:0]        w_basex, w_basey, w_asx, w_asy, w_bsx, w_bsy;
  logic signed [W:0]   w_ax, w_ay, w_bx, w_by;
  logic [2*W+1:0]      w_p1, w_p2;
  logic signed [2*W+2:0] w_cross;
  logic                w_neg, w_zero;

  // Sort compares (v[j]-v0) x (v[j+1]-v0); judge computes (v[k+1]-v[k]) x (P-v[k]).
  always_comb begin
    w_ia = r_cnt;
    w_ib = (r_cnt == AW'(NV - 1)) ? '0 : r_cnt + AW'(1);
    if (r_state == SORT) begin
      w_basex = r_vx[0];     w_basey = r_vy[0];
      w_asx   = r_vx[w_ia];  w_asy   = r_vy[w_ia];
      w_bsx   = r_vx[w_ib];  w_bsy   = r_vy[w_ib];
    end else begin
      w_basex = r_vx[w_ia];  w_basey = r_vy[w_ia];
      w_asx   = r_vx[w_ib];  w_asy   = r_vy[w_ib];
      w_bsx   = r_px;        w_bsy   = r_py;
    end
    w_ax = {1'b0, w_asx} - {1'b0, w_basex};
    w_ay = {1'b0, w_asy} - {1'b0, w_basey};
    w_bx = {1'b0, w_bsx} - {1'b0, w_basex};
    w_by = {1'b0, w_bsy} - {1'b0, w_basey};
    w_p1 = {{(W+1){w_ax[W]}}, w_ax} * {{(W+1){w_by[W]}}, w_by};
    w_p2 = {{(W+1){w_bx[W]}}, w_bx} * {{(W+1){w_ay[W]}}, w_ay};
    w_cross = {w_p1[2*W+1], w_p1} - {w_p2[2*W+1], w_p2};
    w_neg  = w_cross[2*W+2];
    w_zero = (w_cross == '0);
  end

  // Coordinate storage has no reset; its contents are meaningless until loaded.
  always_ff @(posedge clk) begin
    if (r_state == LOAD && in_valid) begin
      if (!r_have_p) begin
        r_px <= X;
        r_py <= Y;
      end else begin
        r_vx[r_cnt] <= X;
        r_vy[r_cnt] <= Y;
      end
    end else if (r_state == SORT && w_neg) begin
      r_vx[w_ia] <= r_vx[w_ib];
      r_vy[w_ia] <= r_vy[w_ib];
      r_vx[w_ib] <= r_vx[w_ia];
      r_vy[w_ib] <= r_vy[w_ia];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= LOAD;
      r_cnt     <= '0;
      r_lim     <= '0;
      r_have_p  <= 1'b0;
      r_flag    <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      is_inside <= 1'b0;
      on_edge   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        LOAD: begin
          if (in_valid) begin
            if (!r_have_p) begin
              r_have_p <= 1'b1;
            end else if (r_cnt == AW'(NV - 1)) begin
              r_state  <= SORT;
              busy     <= 1'b1;
              r_have_p <= 1'b0;
              r_cnt    <= AW'(1);
              r_lim    <= AW'(NV - 2);
            end else begin
              r_cnt <= r_cnt + AW'(1);
            end
          end
        end
        SORT: begin
          // r_lim counts down the last j of each pass; pass with r_lim==1 is the final one.
          if (r_cnt == r_lim) begin
            if (r_lim == AW'(1)) begin
              r_state <= JUDGE;
              r_cnt   <= '0;
              r_flag  <= 1'b0;
            end else begin
              r_lim <= r_lim - AW'(1);
              r_cnt <= AW'(1);
            end
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        JUDGE: begin
          if (w_neg) begin
            r_state   <= OUT;
            valid     <= 1'b1;
            is_inside <= 1'b0;
            on_edge   <= 1'b0;
          end else if (r_cnt == AW'(NV - 1)) begin
            r_state   <= OUT;
            valid     <= 1'b1;
            on_edge   <= r_flag | w_zero;
            is_inside <= !(r_flag || w_zero) || (INCL_EDGE != 0);
          end else begin
            r_cnt <= r_cnt + AW'(1);
            if (w_zero) r_flag <= 1'b1;
          end
        end
        OUT: begin
          r_state <= LOAD;
          busy    <= 1'b0;
          r_cnt   <= '0;
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_geofence_param.sv
// Bench for geofence_param: three instances (default, INCL_EDGE=0, NV=3/W=12),
// an angle-rank/edge-walk reference model and a per-cycle output comparator.
module tb_geofence_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic iv0, iv2;
  logic [9:0]  x0, y0;
  logic [11:0] x2, y2;
  logic [2:0]  bsy, vld, ins, oe;

  always #5 clk = ~clk;

  geofence_param #(.W(10), .NV(6), .INCL_EDGE(1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .X(x0), .Y(y0),
    .busy(bsy[0]), .valid(vld[0]), .is_inside(ins[0]), .on_edge(oe[0]));
  geofence_param #(.W(10), .NV(6), .INCL_EDGE(0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv0), .X(x0), .Y(y0),
    .busy(bsy[1]), .valid(vld[1]), .is_inside(ins[1]), .on_edge(oe[1]));
  geofence_param #(.W(12), .NV(3), .INCL_EDGE(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .X(x2), .Y(y2),
    .busy(bsy[2]), .valid(vld[2]), .is_inside(ins[2]), .on_edge(oe[2]));

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int t_cap[2] = '{-1, -1};
  int t_val[2] = '{-1, -1};
  int obs_lat[2] = '{-1, -1};
  int lat_q[$];
  bit n_in[3], n_oe[3], e_in[3], e_oe[3];

  int HX[8] = '{200, 100, 0, 300, 100, 200, 0, 0};
  int HY[8] = '{0, 0, 100, 100, 200, 200, 0, 0};
  int TX[8] = '{0, 4000, 0, 0, 0, 0, 0, 0};
  int TY[8] = '{0, 0, 4000, 0, 0, 0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint xp(input longint ax, input longint ay, input longint bx, input longint by);
    return ax * by - bx * ay;
  endfunction

  // Place each vertex by its angular rank about v0, then walk the CCW edges.
  function automatic void model(input int px, input int py, input int xs[8], input int ys[8],
                                input int n, output int m, output bit neg, output bit flag);
    int sx[8], sy[8];
    int r, kn;
    longint c;
    sx = '{default: 0};
    sy = '{default: 0};
    sx[0] = xs[0];
    sy[0] = ys[0];
    for (int i = 1; i < n; i++) begin
      r = 0;
      for (int j = 1; j < n; j++)
        if (j != i && xp(xs[i] - xs[0], ys[i] - ys[0], xs[j] - xs[0], ys[j] - ys[0]) < 0) r++;
      sx[1 + r] = xs[i];
      sy[1 + r] = ys[i];
    end
    m = n; neg = 1'b0; flag = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!neg) begin
        kn = (k + 1) % n;
        c = xp(sx[kn] - sx[k], sy[kn] - sy[k], px - sx[k], py - sy[k]);
        if (c < 0) begin
          neg = 1'b1;
          m = k + 1;
        end else if (c == 0) flag = 1'b1;
      end
    end
  endfunction

  task automatic drive(input int grp, input bit v, input int x, input int y);
    if (grp == 0) begin
      iv0 = v; x0 = 10'(x); y0 = 10'(y);
    end else begin
      iv2 = v; x2 = 12'(x); y2 = 12'(y);
    end
  endtask

  task automatic send(input int grp, input int px, input int py, input int xs[8], input int ys[8],
                      input int n, input bit gaps);
    int m, w;
    bit neg, flag;
    w = 0;
    while (cyc <= t_val[grp] && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      n_chk++; n_err++;
      $display("FAIL free_wait: got busy past %0d cycles, expected idle", w);
    end
    obs_lat[grp] = -1;
    for (int i = 0; i <= n; i++) begin
      if (gaps) repeat (int'($urandom_range(0, 3))) begin
        drive(grp, 1'b0, 0, 0);
        @(negedge clk);
      end
      if (i == 0) drive(grp, 1'b1, px, py);
      else        drive(grp, 1'b1, xs[i-1], ys[i-1]);
      if (i == n) begin
        model(px, py, xs, ys, n, m, neg, flag);
        t_cap[grp] = cyc;
        t_val[grp] = cyc + ((n - 2) * (n - 1)) / 2 + m + 1;
        if (grp == 0) begin
          n_in[0] = !neg;
          n_in[1] = !neg && !flag;
          n_oe[0] = !neg && flag;
          n_oe[1] = !neg && flag;
        end else begin
          n_in[2] = !neg;
          n_oe[2] = !neg && flag;
        end
      end
      @(negedge clk);
    end
    drive(grp, 1'b0, 0, 0);
  endtask

  task automatic wait_done(input int grp);
    int w;
    w = 0;
    while (cyc <= t_val[grp] && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout: got no completion in %0d cycles, expected valid", w);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      int k;
      bit ev, eb;
      k  = (g == 2) ? 1 : 0;
      ev = (t_val[k] >= 0) && (cyc == t_val[k]);
      eb = (t_val[k] >= 0) && (cyc > t_cap[k]) && (cyc <= t_val[k]);
      if (ev) begin
        e_in[g] = n_in[g];
        e_oe[g] = n_oe[g];
      end
      if (vld[g] && g != 1) begin
        obs_lat[k] = cyc - t_cap[k];
        if (g == 2) lat_q.push_back(cyc - t_cap[k]);
      end
      chk($sformatf("valid%0d", g), vld[g], ev);
      chk($sformatf("busy%0d", g), bsy[g], eb);
      chk($sformatf("is_inside%0d", g), ins[g], e_in[g]);
      chk($sformatf("on_edge%0d", g), oe[g], e_oe[g]);
    end
  end

  initial begin
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    send(0, 150, 100, HX, HY, 6, 1'b0);
    wait_done(0);
    chk("t1_latency", obs_lat[0], 17);
    chk("t1_inside", ins[0], 1);
    chk("t1_on_edge", oe[0], 0);

    send(0, 400, 100, HX, HY, 6, 1'b0);
    wait_done(0);
    chk("t2_latency", obs_lat[0], 12);
    chk("t2_inside", ins[0], 0);

    send(0, 0, 0, HX, HY, 6, 1'b0);
    wait_done(0);
    chk("corner_latency", obs_lat[0], 16);

    send(0, 150, 0, HX, HY, 6, 1'b0);
    wait_done(0);
    chk("t3_on_edge", oe[0], 1);
    chk("t3_inside_incl", ins[0], 1);
    chk("t3_inside_excl", ins[1], 0);

    send(0, 300, 100, HX, HY, 6, 1'b0);
    wait_done(0);

    send(0, 150, 100, HX, HY, 6, 1'b1);
    wait_done(0);
    chk("t4_latency", obs_lat[0], 17);
    chk("t4_inside", ins[0], 1);

    send(0, 150, 100, HX, HY, 6, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    t_val[0] = -1;
    for (int g = 0; g < 2; g++) begin
      e_in[g] = 1'b0;
      e_oe[g] = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(0, 400, 100, HX, HY, 6, 1'b0);
    wait_done(0);
    chk("t5_latency", obs_lat[0], 12);
    chk("t5_inside", ins[0], 0);

    send(1, 1000, 1000, TX, TY, 3, 1'b0);
    send(1, 3000, 3000, TX, TY, 3, 1'b0);
    wait_done(1);
    chk("t6_count", lat_q.size(), 2);
    if (lat_q.size() == 2) begin
      chk("t6_latency_a", lat_q[0], 5);
      chk("t6_latency_b", lat_q[1], 4);
    end
    chk("t6_inside_b", ins[2], 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
